// File: rtl/rx_fifo_buffer.sv
// Receive-side FIFO: captures bytes from a UART receive block via a Clr_RX_Flag handshake
// into a show-ahead FIFO. Define RX_DROP_PERR_EN to discard bytes received with a parity error.
module rx_fifo_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            Data_RX,
  input  logic                  Parity_Error,
  input  logic                  RX_Flag,
  output logic                  Clr_RX_Flag,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rd_perr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overrun,
  input  logic                  clr_overrun
);

`ifdef RX_DROP_PERR_EN
  localparam int unsigned EntryW = 8;
`else
  localparam int unsigned EntryW = 9;
`endif
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StAck, StWaitLow} state_e;

  state_e                state_q, state_d;
  logic [EntryW-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  capture, store_req, pop, push, drop;
  logic [EntryW-1:0]     wr_entry;

  // Capture FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (RX_Flag) state_d = StAck;
      StAck:     state_d = StWaitLow;
      StWaitLow: if (!RX_Flag) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Capture FSM: outputs; Clr_RX_Flag decodes registered state only, so it is glitch-free
  always_comb begin
    Clr_RX_Flag = (state_q == StIdle);
    capture     = (state_q == StIdle) && RX_Flag;
  end

`ifdef RX_DROP_PERR_EN
  assign store_req = capture && !Parity_Error;
  assign wr_entry  = Data_RX;
`else
  assign store_req = capture;
  assign wr_entry  = {Parity_Error, Data_RX};
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);
  assign count = count_q;
  assign overrun = overrun_q;

  // A pop on the same edge frees the slot, so a capture while full is still accepted.
  assign pop  = rd_en && !empty;
  assign push = store_req && (!full || pop);
  assign drop = store_req && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A drop on the same edge as clr_overrun keeps the flag set.
  assign overrun_d = drop | (overrun_q & ~clr_overrun);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

  assign rd_data = mem[rd_ptr_q][7:0];
`ifdef RX_DROP_PERR_EN
  assign rd_perr = 1'b0;
`else
  assign rd_perr = mem[rd_ptr_q][8];
`endif

endmodule

// File: tb/tb_rx_fifo_buffer.sv
// Randomized scoreboard bench for rx_fifo_buffer: a queue model predicts FIFO contents and
// flags, and a negedge monitor compares every pop and status output against it.
module tb_rx_fifo_buffer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
`ifdef RX_DROP_PERR_EN
  localparam bit DropPerr = 1'b1;
`else
  localparam bit DropPerr = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    Data_RX;
  logic          Parity_Error;
  logic          RX_Flag;
  logic          Clr_RX_Flag;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;
  logic          clr_overrun;

  int checks = 0;
  int errors = 0;

  logic [8:0] model_q[$];
  logic [8:0] exp_q[$];
  bit         ack_pending = 1'b0;
  bit         in_wait     = 1'b0;
  bit         m_overrun   = 1'b0;
  bit         mon_en      = 1'b0;

  rx_fifo_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .Data_RX      (Data_RX),
    .Parity_Error (Parity_Error),
    .RX_Flag      (RX_Flag),
    .Clr_RX_Flag  (Clr_RX_Flag),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_perr      (rd_perr),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: status every cycle, data whenever the DUT presents a pop.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 32'(count), 32'(model_q.size()));
      check("empty", 32'(empty), 32'(model_q.size() == 0));
      check("full", 32'(full), 32'(model_q.size() == DEPTH));
      check("overrun", 32'(overrun), 32'(m_overrun));
      check("clr_rx_flag", 32'(Clr_RX_Flag), 32'(!ack_pending));
      if (rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: DUT popped %0h but no entry expected", rd_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(e[7:0]));
          check("rd_perr", 32'(rd_perr), 32'(e[8]));
        end
      end
    end
  end

  // Reference model: apply the inputs that were present at the edge just taken.
  task automatic model_edge();
    bit pop;
    bit cap;
    bit keep;
    pop  = rd_en && (model_q.size() > 0);
    cap  = !ack_pending && RX_Flag;
    keep = cap && !(DropPerr && Parity_Error);
    if (pop) void'(model_q.pop_front());
    if (keep && model_q.size() < DEPTH) model_q.push_back({Parity_Error, Data_RX});
    if (keep && model_q.size() >= DEPTH && !pop && full) m_overrun = 1'b1;
    else if (clr_overrun) m_overrun = 1'b0;
    if (cap) begin
      ack_pending = 1'b1;
      in_wait     = 1'b0;
    end else if (ack_pending) begin
      if (in_wait && !RX_Flag) ack_pending = 1'b0;
      else in_wait = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_rd(input bit en);
    rd_en = en;
    if (en && model_q.size() > 0) exp_q.push_back(model_q[0]);
  endtask

  task automatic run(input int n, input int rd_pct, input int tx_pct);
    for (int i = 0; i < n; i++) begin
      step();
      clr_overrun = ($urandom_range(99) < 5);
      if (!RX_Flag && !ack_pending && $urandom_range(99) < tx_pct) begin
        RX_Flag      = 1'b1;
        Data_RX      = 8'($urandom);
        Parity_Error = ($urandom_range(9) == 0);
      end else if (RX_Flag && ack_pending && $urandom_range(99) < 60) begin
        RX_Flag = 1'b0;
      end
      set_rd($urandom_range(99) < rd_pct);
    end
  endtask

  initial begin
    reset = 1'b1; Data_RX = '0; Parity_Error = 1'b0; RX_Flag = 1'b0;
    rd_en = 1'b0; clr_overrun = 1'b0;
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_clr_rx_flag", 32'(Clr_RX_Flag), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    run(300, 10, 60);   // mostly filling: full and overrun cases
    run(300, 70, 60);   // draining: empty reads ignored
    run(400, 40, 50);   // mixed: simultaneous write and pop near full

    // Reset in the middle of a handshake with RX_Flag still high.
    clr_overrun = 1'b0; RX_Flag = 1'b0; set_rd(1'b0);
    repeat (4) step();
    Data_RX = 8'hC3; Parity_Error = 1'b0; RX_Flag = 1'b1;
    repeat (3) step();
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midreset_clr_rx_flag", 32'(Clr_RX_Flag), 32'd1);
    check("midreset_count", 32'(count), 32'd0);
    check("midreset_empty", 32'(empty), 32'd1);
    model_q.delete(); exp_q.delete();
    ack_pending = 1'b0; in_wait = 1'b0; m_overrun = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    mon_en = 1'b1;
    repeat (2) step();
    check("post_reset_count", 32'(count), 32'd1);
    RX_Flag = 1'b0;
    repeat (3) step();
    check("post_reset_single_capture", 32'(count), 32'd1);
    set_rd(1'b1);
    step();
    set_rd(1'b0);
    repeat (2) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_fifo_buffer.md
RX_FIFO_BUFFER -- requirements
Module: rx_fifo_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries; power of two, minimum 2.
REQ-002 Parameter ADDR_WIDTH, default 3, log2(DEPTH).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Data_RX  input  8  received byte from the UART receive block.
REQ-006 Parity_Error  input  1  parity error flag of the byte on Data_RX.
REQ-007 RX_Flag  input  1  high while a received byte is pending.
REQ-008 Clr_RX_Flag  output  1  acknowledge to the receive block; active-low (0 = clear pending flag).
REQ-009 rd_en  input  1  pop request from the consumer.
REQ-010 rd_data  output  8  byte at the FIFO head (show-ahead).
REQ-011 rd_perr  output  1  parity error bit stored with the head byte.
REQ-012 empty  output  1  FIFO holds zero entries.
REQ-013 full  output  1  FIFO holds DEPTH entries.
REQ-014 count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
REQ-015 overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-016 clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-017 The capture FSM SHALL have exactly three states: IDLE, ACK, WAIT_LOW.
REQ-018 In IDLE with RX_Flag=1 at a rising edge, the block SHALL write {Parity_Error, Data_RX} into the FIFO on that edge and enter ACK.
REQ-019 In ACK, Clr_RX_Flag SHALL be 0 (registered output, one cycle after the capture edge), and the FSM SHALL move to WAIT_LOW on the next edge.
REQ-020 In WAIT_LOW, Clr_RX_Flag SHALL stay 0 until RX_Flag is sampled 0; the FSM then returns to IDLE and Clr_RX_Flag returns to 1 on that edge.
REQ-021 Clr_RX_Flag SHALL be 1 in IDLE; each received byte SHALL be written at most once.
REQ-022 A capture while full and rd_en=0 SHALL drop the byte, set overrun on the same edge, and still run the ACK/WAIT_LOW handshake.
REQ-023 A capture while full with rd_en=1 on the same edge SHALL be accepted; count stays DEPTH.
REQ-024 rd_en with empty=1 SHALL be ignored: no pointer or count change, no error flag.
REQ-025 Simultaneous accepted write and pop SHALL leave count unchanged; write-only increments count, pop-only decrements it.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; empty = (count==0), full = (count==DEPTH), both derived from count.
REQ-027 rd_data/rd_perr SHALL reflect the head entry combinationally from storage; they are don't-care while empty.
REQ-028 clr_overrun=1 SHALL clear overrun on the next edge; if a drop occurs on the same edge, overrun SHALL remain 1 (set wins).

Reset
REQ-029 reset=1 SHALL asynchronously force: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overrun=0, Clr_RX_Flag=1.
REQ-030 Storage array contents SHALL NOT be reset.
REQ-031 Reset asserted mid-handshake (ACK or WAIT_LOW) SHALL abandon the handshake; a still-high RX_Flag after release SHALL be captured as a new byte.

Configuration
REQ-032 Macro RX_DROP_PERR_EN: when defined, a byte with Parity_Error=1 SHALL NOT be written, but SHALL be acknowledged normally; it SHALL NOT set overrun; rd_perr SHALL be tied 0.
REQ-033 Without RX_DROP_PERR_EN, all bytes SHALL be stored with their parity bit and returned on rd_perr.

Verification
REQ-034 Single byte: Data_RX=0x5A, Parity_Error=0, RX_Flag pulse held until Clr_RX_Flag=0 -> count=1, rd_data=0x5A, rd_perr=0, Clr_RX_Flag low from 1 cycle after capture until RX_Flag drops.
REQ-035 Fill/wrap: write 0x01..0x08, pop 4, write 0x09..0x0C -> full=1, pops return 0x05..0x0C in order, then empty=1.
REQ-036 Overrun: fill 8 bytes, send 0xFF with rd_en=0 -> overrun=1, count=8, byte absent; clr_overrun -> overrun=0 next cycle.
REQ-037 Full write+pop same edge: full, send 0xAA with rd_en=1 -> count=8, overrun=0, 0xAA is last entry popped.
REQ-038 Parity byte 0x33 with Parity_Error=1 -> without macro: stored, rd_perr=1; with RX_DROP_PERR_EN: count unchanged, Clr_RX_Flag still pulses low.
REQ-039 Reset during WAIT_LOW with RX_Flag held high -> Clr_RX_Flag=1 immediately, count=0; after release, byte captured once, count=1.
